// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch queue.
package fetch_pkg;

    localparam int unsigned FETCH_INSTR_W = 32;
    localparam int unsigned FETCH_ADDR_W  = 9;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic is_known_opcode(input logic [6:0] opc);
        return (opc == R_TYPE) || (opc == I_TYPE) || (opc == LW) || (opc == SW) ||
               (opc == BR) || (opc == JAL) || (opc == JALR);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush has priority over push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output entry_t                 head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch/prefetch buffer: one outstanding imem request, small FIFO
// toward decode, flush and restart on a downstream redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 9,
    parameter int unsigned       INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [6:0]         dec_opcode,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [CNT_W-1:0]  count, count_next;
    entry_t            head, push_data;
    logic              push, pop, room, issue;
    logic              unused_redirect_lsb;

    assign dec_valid  = (count != '0);
    assign pop        = dec_valid && dec_ready && !redirect_valid;
    assign push       = (state_q == WAIT) && imem_rvalid && !redirect_valid;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign room       = (count_next < CNT_W'(DEPTH));
    assign push_data  = '{instr: imem_rdata, pc: req_pc_q};

    // A request may only go out when its response is guaranteed a FIFO slot.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        issue      = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
            state_d    = ((state_q != IDLE) && !imem_rvalid) ? DISCARD : IDLE;
        end else begin
            unique case (state_q)
                IDLE: issue = room;
                WAIT, DISCARD: begin
                    if (imem_rvalid) begin
                        issue   = room;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (issue) begin
                state_d    = WAIT;
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign imem_req            = rst_n && issue;
    assign imem_addr           = fetch_pc_q;
    assign dec_instr           = dec_valid ? head.instr : INSTR_W'(NOP_INSTR);
    assign dec_opcode          = dec_instr[6:0];
    assign dec_pc              = dec_valid ? head.pc : '0;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    a_no_rvalid_in_idle: assert property (
        @(posedge clk) disable iff (!rst_n) !((state_q == IDLE) && imem_rvalid)
    );

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch and prefetch buffer that produces the instruction stream consumed by the decode stage (main controller and immediate generator).
- Issues word requests to instruction memory, buffers returned instructions in a small FIFO, and presents the head instruction, its PC and opcode field to decode under a valid/ready handshake.
- Consumes the taken-branch/jump redirect produced downstream: flushes the queue and restarts fetch at the target.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 9, byte-address width of PC and instruction-memory address.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  single-cycle fetch request pulse.
- imem_addr  out  ADDR_W  word-aligned fetch address, meaningful when imem_req=1.
- imem_rvalid  in  1  response valid, one cycle per request.
- imem_rdata  in  INSTR_W  response instruction.
- dec_valid  out  1  head entry available to decode.
- dec_ready  in  1  decode accepts head this cycle.
- dec_instr  out  INSTR_W  head instruction; 32'h00000013 (NOP) when empty.
- dec_opcode  out  7  dec_instr[6:0].
- dec_pc  out  ADDR_W  PC of head instruction; 0 when empty.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  ADDR_W  redirect target.

Behaviour:
- Reset (async assert, sync release):
  - imem_req=0, imem_addr=RESET_PC, dec_valid=0, dec_instr=NOP, dec_pc=0.
  - FIFO count=0, FSM=IDLE, fetch_pc=RESET_PC.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding.
  - DISCARD: one outstanding response to be dropped.
- Issue rule: at most one outstanding request. imem_req=1 when (IDLE, or WAIT with imem_rvalid=1 this cycle) and count_after_this_cycle < DEPTH. Space is always reserved, so the FIFO never overflows.
- On issue: imem_addr=fetch_pc; fetch_pc += 4, modulo 2^ADDR_W (wraps to 0, no error); FSM goes to WAIT.
- Response in WAIT: {imem_rdata, request addr} is written at the FIFO tail at the clock edge. It is visible to decode next cycle (dec_valid rises one cycle after imem_rvalid).
- Back-to-back: with 1-cycle memory latency and dec_ready=1, sustain one instruction per cycle.
- Dequeue: when dec_valid && dec_ready, pop the head. Enqueue and dequeue in the same cycle leaves count unchanged.
- Redirect (highest priority):
  - FIFO flushed; dec_valid=0 next cycle.
  - fetch_pc = {redirect_pc[ADDR_W-1:2], 2'b00}; misaligned low bits are ignored.
  - If a request is outstanding and its response did not arrive this cycle, FSM goes to DISCARD; otherwise to IDLE.
  - A response arriving in the redirect cycle is dropped.
  - No imem_req in the redirect cycle; the first target request issues the next cycle (from IDLE) or after the discarded response.
  - A dec_ready handshake in the redirect cycle is ignored; decode treats the current head as squashed.
- DISCARD: the arriving imem_rvalid is dropped. In that same cycle a request to the new fetch_pc issues (if no further redirect) and FSM goes to WAIT.
- A redirect while in DISCARD updates fetch_pc and stays in DISCARD.
- imem_rvalid in IDLE is a protocol error: ignored, with an assertion in simulation.
- Reset mid-request: all state cleared immediately; a late response after reset release while IDLE is ignored.
- Outputs are registered or derived from FIFO head registers; there is no combinational path from dec_ready to imem_req beyond count arithmetic.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR constant (32'h00000013).
  - Opcode constants: R_TYPE, I_TYPE, LW, SW, BR, JAL, JALR.
  - typedef fetch_state_e {IDLE, WAIT, DISCARD}.
  - typedef fetch_entry_t {instr, pc}.
- One sub-module: fetch_fifo, a synchronous FIFO of fetch_entry_t with DEPTH, push, pop, flush, count, head outputs and an asynchronous active-low reset. Flush has priority over push.

Test Plan:
- Reset release, 1-cycle memory, dec_ready=1 -> imem_addr 0x000, 0x004, 0x008 on consecutive cycles; dec_valid from cycle 3; dec_pc tracks 0x000, 0x004, …; dec_opcode=rdata[6:0].
- dec_ready=0, DEPTH=4 -> exactly 4 requests (0x000–0x00C), then imem_req stays 0. Raising dec_ready for one cycle -> one request for 0x010.
- Redirect to 0x040 while a request is outstanding with 3-cycle latency -> stale response dropped (never appears on dec_instr); next imem_addr=0x040; first dec_pc after flush = 0x040.
- Redirect to 0x043 in the same cycle as imem_rvalid -> response dropped; next request addr 0x040; dec_valid=0 the cycle after the redirect.
- fetch_pc=0x1FC, ADDR_W=9 -> next request after 0x1FC is 0x000.
- Assert rst_n=0 mid-WAIT with a full FIFO -> outputs immediately at reset values (dec_instr=NOP); after release the first request is RESET_PC.
